// File: rtl/event_change_logger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : event_change_logger                                        |
// | Description : Registered OR/XOR/NOT reductions of a sampled bus, plus a  |
// |               change logger that queues {timestamp, sample} records in a |
// |               valid/ready drained FIFO. Optional macro CHG_MASK_EN adds  |
// |               a per-channel change-enable mask input (chan_mask).        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module event_change_logger #(
   parameter int NCH   = 5,
   parameter int DEPTH = 8,
   parameter int TS_W  = 16,
   parameter int CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NCH-1:0]            in_bus,
   output logic                      red_or,
   output logic                      red_xor,
   output logic [NCH-1:0]            inv_out,
   output logic                      rec_valid,
   input  logic                      rec_ready,
   output logic [TS_W+NCH-1:0]       rec_data,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic [CNT_W-1:0]          evt_cnt,
   output logic [CNT_W-1:0]          drop_cnt
`ifdef CHG_MASK_EN
   ,
   input  logic [NCH-1:0]            chan_mask
`endif
);

   localparam int                  c_ADDR_W   = $clog2(DEPTH);
   localparam int                  c_LVL_W    = c_ADDR_W + 1;
   localparam int                  c_REC_W    = TS_W + NCH;
   localparam logic [c_LVL_W-1:0]  c_FULL_LVL = c_LVL_W'(DEPTH);

   logic [NCH-1:0]      r_in_q;
   logic [NCH-1:0]      r_in_prev;
   logic [TS_W-1:0]     r_ts;
   logic                r_red_or;
   logic                r_red_xor;
   logic [NCH-1:0]      r_inv;
   logic [c_REC_W-1:0]  r_mem [DEPTH];
   logic [c_ADDR_W-1:0] r_wr_ptr;
   logic [c_ADDR_W-1:0] r_rd_ptr;
   logic [c_LVL_W-1:0]  r_level;
   logic [CNT_W-1:0]    r_evt_cnt;
   logic [CNT_W-1:0]    r_drop_cnt;

   logic [NCH-1:0]      w_mask;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic                w_wr_en;
   logic                w_drop;

`ifdef CHG_MASK_EN
   assign w_mask = chan_mask;
`else
   assign w_mask = {NCH{1'b1}};
`endif

   assign w_empty = (r_level == '0);
   assign w_full  = (r_level == c_FULL_LVL);
   assign w_push  = (((r_in_q ^ r_in_prev) & w_mask) != '0);
   assign w_pop   = !w_empty && rec_ready;
   // A full FIFO still accepts a record when the head leaves on the same edge.
   assign w_wr_en = w_push && (!w_full || w_pop);
   assign w_drop  = w_push && w_full && !w_pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_q    <= '0;
         r_in_prev <= '0;
         r_ts      <= '0;
         r_red_or  <= 1'b0;
         r_red_xor <= 1'b0;
         r_inv     <= {NCH{1'b1}};
      end else begin
         r_in_q    <= in_bus;
         r_in_prev <= r_in_q;
         r_ts      <= r_ts + TS_W'(1);
         r_red_or  <= |r_in_q;
         r_red_xor <= ^r_in_q;
         r_inv     <= ~r_in_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {r_ts, r_in_q};
            r_wr_ptr        <= r_wr_ptr + c_ADDR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
         end
         case ({w_wr_en, w_pop})
            2'b10:   r_level <= r_level + c_LVL_W'(1);
            2'b01:   r_level <= r_level - c_LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Events are counted whether or not the record fits; drops saturate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_evt_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_push) begin
            r_evt_cnt <= r_evt_cnt + CNT_W'(1);
         end
         if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
         end
      end
   end

   assign red_or     = r_red_or;
   assign red_xor    = r_red_xor;
   assign inv_out    = r_inv;
   assign rec_valid  = !w_empty;
   assign rec_data   = r_mem[r_rd_ptr];
   assign fifo_level = r_level;
   assign evt_cnt    = r_evt_cnt;
   assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_event_change_logger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_event_change_logger                                     |
// | Description : Directed bench with a record scoreboard for                |
// |               event_change_logger (mask section under CHG_MASK_EN).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_event_change_logger;

   localparam int NCH   = 5;
   localparam int DEPTH = 8;
   localparam int TS_W  = 16;
   localparam int CNT_W = 16;
   localparam int RW    = TS_W + NCH;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NCH-1:0]         in_bus;
   logic                   red_or;
   logic                   red_xor;
   logic [NCH-1:0]         inv_out;
   logic                   rec_valid;
   logic                   rec_ready;
   logic [RW-1:0]          rec_data;
   logic [$clog2(DEPTH):0] fifo_level;
   logic [CNT_W-1:0]       evt_cnt;
   logic [CNT_W-1:0]       drop_cnt;
   logic [NCH-1:0]         mask;

   int checks   = 0;
   int failures = 0;

   logic [RW-1:0]    sb[$];
   logic [NCH-1:0]   v1;
   logic [NCH-1:0]   v2;
   logic [TS_W-1:0]  e_ts;
   logic [CNT_W-1:0] exp_evt;
   logic [CNT_W-1:0] exp_drop;

   event_change_logger #(
      .NCH   (NCH),
      .DEPTH (DEPTH),
      .TS_W  (TS_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_bus     (in_bus),
      .red_or     (red_or),
      .red_xor    (red_xor),
      .inv_out    (inv_out),
      .rec_valid  (rec_valid),
      .rec_ready  (rec_ready),
      .rec_data   (rec_data),
      .fifo_level (fifo_level),
      .evt_cnt    (evt_cnt),
      .drop_cnt   (drop_cnt)
`ifdef CHG_MASK_EN
      ,
      .chan_mask  (mask)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; spans exactly one rising edge.
   task automatic tick(input logic [NCH-1:0] v, input logic rdy);
      logic [NCH-1:0] src;
      logic [RW-1:0]  tmp;
      in_bus    = v;
      rec_ready = rdy;
      #1;
      chk("rec_valid", {63'd0, rec_valid}, {63'd0, sb.size() != 0});
      if (sb.size() != 0) begin
         chk("rec_data", {43'd0, rec_data}, {43'd0, sb[0]});
         if (rdy) tmp = sb.pop_front();
      end
      if (((v1 ^ v2) & mask) != '0) begin
         exp_evt = exp_evt + CNT_W'(1);
         if (sb.size() < DEPTH) sb.push_back({e_ts, v1});
         else if (exp_drop != {CNT_W{1'b1}}) exp_drop = exp_drop + CNT_W'(1);
      end
      src  = v1;
      v2   = v1;
      v1   = v;
      e_ts = e_ts + TS_W'(1);
      @(posedge clk);
      @(negedge clk);
      chk("red_or", {63'd0, red_or}, {63'd0, |src});
      chk("red_xor", {63'd0, red_xor}, {63'd0, ^src});
      chk("inv_out", {59'd0, inv_out}, {59'd0, ~src});
      chk("fifo_level", {60'd0, fifo_level}, 64'(sb.size()));
      chk("evt_cnt", {48'd0, evt_cnt}, {48'd0, exp_evt});
      chk("drop_cnt", {48'd0, drop_cnt}, {48'd0, exp_drop});
   endtask

   task automatic do_reset(input logic [NCH-1:0] hold);
      in_bus    = hold;
      rec_ready = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_red_or", {63'd0, red_or}, 64'd0);
      chk("rst_red_xor", {63'd0, red_xor}, 64'd0);
      chk("rst_inv_out", {59'd0, inv_out}, {59'd0, {NCH{1'b1}}});
      chk("rst_rec_valid", {63'd0, rec_valid}, 64'd0);
      chk("rst_rec_data", {43'd0, rec_data}, 64'd0);
      chk("rst_fifo_level", {60'd0, fifo_level}, 64'd0);
      chk("rst_evt_cnt", {48'd0, evt_cnt}, 64'd0);
      chk("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
      sb.delete();
      v1       = '0;
      v2       = '0;
      e_ts     = '0;
      exp_evt  = '0;
      exp_drop = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [TS_W-1:0] ts_prev;
      logic [TS_W-1:0] ts_now;
      logic [NCH-1:0]  tv;
      rst       = 1'b1;
      in_bus    = '0;
      rec_ready = 1'b0;
      mask      = {NCH{1'b1}};
      ts_prev   = '0;

      // Quiet bus: no records, reductions at their idle values.
      do_reset('0);
      repeat (20) tick('0, 1'b1);
      chk("t1_evt_cnt", {48'd0, evt_cnt}, 64'd0);
      chk("t1_inv_out", {59'd0, inv_out}, 64'h1F);

      // Single change: reductions two edges later, one record.
      tick(5'b00011, 1'b1);
      tick(5'b00011, 1'b1);
      chk("t2_red_or", {63'd0, red_or}, 64'd1);
      chk("t2_red_xor", {63'd0, red_xor}, 64'd0);
      chk("t2_rec_valid", {63'd0, rec_valid}, 64'd1);
      chk("t2_sample", {59'd0, rec_data[NCH-1:0]}, 64'h03);
      chk("t2_evt_cnt", {48'd0, evt_cnt}, 64'd1);
      tick(5'b00011, 1'b1);
      chk("t2_drained", {60'd0, fifo_level}, 64'd0);

      // Overflow with the consumer stalled, then drain oldest-first.
      do_reset('0);
      for (int i = 0; i < 12; i++) tick((i % 2 == 0) ? 5'h01 : 5'h00, 1'b0);
      tick(5'h00, 1'b0);
      tick(5'h00, 1'b0);
      chk("t3_level", {60'd0, fifo_level}, 64'd8);
      chk("t3_drop_cnt", {48'd0, drop_cnt}, 64'd4);
      chk("t3_evt_cnt", {48'd0, evt_cnt}, 64'd12);
      for (int j = 0; j < 8; j++) begin
         ts_now = rec_data[RW-1:NCH];
         if (j > 0) chk("t3_ts_step", {48'd0, ts_now}, {48'd0, ts_prev + TS_W'(1)});
         ts_prev = ts_now;
         tick(5'h00, 1'b1);
      end
      chk("t3_empty", {60'd0, fifo_level}, 64'd0);

      // Full FIFO with simultaneous push and pop every edge.
      tv = 5'h00;
      for (int i = 0; i < 9; i++) begin
         tv = tv ^ 5'h04;
         tick(tv, 1'b0);
      end
      for (int i = 0; i < 12; i++) begin
         tv = tv ^ 5'h04;
         tick(tv, 1'b1);
         chk("t4_level", {60'd0, fifo_level}, 64'd8);
      end
      chk("t4_drop_cnt", {48'd0, drop_cnt}, 64'd4);

      // Reset mid-operation; timestamps restart and a held nonzero bus logs once.
      do_reset('0);
      for (int i = 0; i < 5; i++) tick((i % 2 == 0) ? 5'h10 : 5'h00, 1'b0);
      tick(5'h10, 1'b0);
      chk("t5_level", {60'd0, fifo_level}, 64'd5);
      do_reset(5'h10);
      tick(5'h10, 1'b1);
      tick(5'h10, 1'b1);
      chk("t5_rec_valid", {63'd0, rec_valid}, 64'd1);
      chk("t5_ts", {48'd0, rec_data[RW-1:NCH]}, 64'd1);
      tick(5'h10, 1'b1);
      chk("t5_evt_cnt", {48'd0, evt_cnt}, 64'd1);

`ifdef CHG_MASK_EN
      // Masked channel toggles alone are ignored but still appear in the sample.
      do_reset('0);
      mask = 5'b11110;
      tick(5'b00001, 1'b1);
      tick(5'b00000, 1'b1);
      tick(5'b00001, 1'b1);
      tick(5'b00001, 1'b1);
      chk("t6_no_rec", {48'd0, evt_cnt}, 64'd0);
      tick(5'b10001, 1'b1);
      tick(5'b10001, 1'b1);
      chk("t6_rec_valid", {63'd0, rec_valid}, 64'd1);
      chk("t6_sample", {59'd0, rec_data[NCH-1:0]}, 64'h11);
      tick(5'b10001, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
